cdb_issue_scheduler: RTL and testbench

- Backend issue scheduler between the four dispatch queues (integer, multiply, divide, memory) and the execution units.
- Each cycle it grants issue to ready queues only when their result's common data bus (CDB) slot, at a fixed latency, is free. This guarantees at most one CDB writer per cycle.
- It tracks the busy state of the non-pipelined divider.
- It tells the CDB mux which unit drives the bus in each cycle.

---
 rtl/backend_pkg.sv | 18 +
 rtl/cdb_slot_ring.sv | 45 ++++
 rtl/cdb_issue_scheduler.sv | 117 +++++++++++
 tb/tb_cdb_issue_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/backend_pkg.sv
// Shared backend types: CDB owner encoding and default unit latencies.
// The reservation window must stay longer than the longest unit latency.
package backend_pkg;

    typedef enum logic [1:0] {
        CU_INT  = 2'd0,
        CU_MULT = 2'd1,
        CU_DIV  = 2'd2,
        CU_MEM  = 2'd3
    } cdb_unit_t;

    localparam int DEF_INT_LAT  = 1;
    localparam int DEF_MULT_LAT = 4;
    localparam int DEF_DIV_LAT  = 7;
    localparam int DEF_MEM_LAT  = 1;
    localparam int RES_DEPTH    = 8;

endpackage

// File: rtl/cdb_slot_ring.sv
// CDB reservation window: slot k holds the bus claim for k cycles ahead and its owner.
// New claims merge in, then the whole window advances one slot per clock.
module cdb_slot_ring
    import backend_pkg::*;
#(
    parameter int DEPTH = RES_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH-1:0]      reserve,
    input  logic [DEPTH-1:0][1:0] reserve_tag,
    output logic [DEPTH-1:0]      slot_busy,
    output cdb_unit_t             head_tag
);

    logic [DEPTH-1:0]      res_q;
    logic [DEPTH-1:0][1:0] own_q;
    logic [DEPTH-1:0]      res_m;
    logic [DEPTH-1:0][1:0] own_m;

    always_comb begin
        res_m = res_q | reserve;
        own_m = own_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (reserve[k]) begin
                own_m[k] = reserve_tag[k];
            end
        end
    end

    // The slot entering at the far end is always empty and tagged as INT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            own_q <= '0;
        end else begin
            res_q <= res_m >> 1;
            own_q <= {2'b00, own_m[DEPTH-1:1]};
        end
    end

    assign slot_busy = res_q;
    assign head_tag  = cdb_unit_t'(own_q[0]);

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Issue scheduler: grants ready queues only when their CDB slot is free, so the
// bus never has two writers; also tracks the non-pipelined divider.
module cdb_issue_scheduler
    import backend_pkg::*;
#(
    parameter int INT_LAT  = DEF_INT_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int MEM_LAT  = DEF_MEM_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_ready,
    input  logic       mult_ready,
    input  logic       div_ready,
    input  logic       mem_ready,
    output logic       int_issue,
    output logic       mult_issue,
    output logic       div_issue,
    output logic       mem_issue,
    output logic       div_busy,
    output logic       cdb_valid,
    output logic [1:0] cdb_sel
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    logic [RES_DEPTH-1:0]      slot_busy;
    logic [RES_DEPTH-1:0]      claim;
    logic [RES_DEPTH-1:0][1:0] claim_tag;
    cdb_unit_t                 head_tag;
    logic [CNT_W-1:0]          div_cnt;
    logic                      rr_mem;
    logic                      int_g, mult_g, div_g, mem_g;
    logic                      unused_slots;

    // The divider may accept a new op in the cycle its current op retires
    // (counter at 1), giving back-to-back divides exactly DIV_LAT apart.
    always_comb begin
        claim     = '0;
        claim_tag = '0;
        int_g     = 1'b0;
        mem_g     = 1'b0;

        div_g = !rst && div_ready && (div_cnt <= CNT_W'(1)) && !slot_busy[DIV_LAT];
        if (div_g) begin
            claim[DIV_LAT]     = 1'b1;
            claim_tag[DIV_LAT] = CU_DIV;
        end

        mult_g = !rst && mult_ready && !slot_busy[MULT_LAT] && !claim[MULT_LAT];
        if (mult_g) begin
            claim[MULT_LAT]     = 1'b1;
            claim_tag[MULT_LAT] = CU_MULT;
        end

        // Favoured unit of the INT/MEM pair is evaluated first.
        if (!rr_mem) begin
            int_g = !rst && int_ready && !slot_busy[INT_LAT] && !claim[INT_LAT];
            if (int_g) begin
                claim[INT_LAT]     = 1'b1;
                claim_tag[INT_LAT] = CU_INT;
            end
            mem_g = !rst && mem_ready && !slot_busy[MEM_LAT] && !claim[MEM_LAT];
            if (mem_g) begin
                claim[MEM_LAT]     = 1'b1;
                claim_tag[MEM_LAT] = CU_MEM;
            end
        end else begin
            mem_g = !rst && mem_ready && !slot_busy[MEM_LAT] && !claim[MEM_LAT];
            if (mem_g) begin
                claim[MEM_LAT]     = 1'b1;
                claim_tag[MEM_LAT] = CU_MEM;
            end
            int_g = !rst && int_ready && !slot_busy[INT_LAT] && !claim[INT_LAT];
            if (int_g) begin
                claim[INT_LAT]     = 1'b1;
                claim_tag[INT_LAT] = CU_INT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_mem  <= 1'b0;
            div_cnt <= '0;
        end else begin
            if (rr_mem ? mem_g : int_g) begin
                rr_mem <= !rr_mem;
            end
            if (div_g) begin
                div_cnt <= CNT_W'(DIV_LAT);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - CNT_W'(1);
            end
        end
    end

    cdb_slot_ring #(.DEPTH(RES_DEPTH)) u_ring (
        .clk         (clk),
        .rst         (rst),
        .reserve     (claim),
        .reserve_tag (claim_tag),
        .slot_busy   (slot_busy),
        .head_tag    (head_tag)
    );

    assign int_issue    = int_g;
    assign mult_issue   = mult_g;
    assign div_issue    = div_g;
    assign mem_issue    = mem_g;
    assign div_busy     = (div_cnt != '0);
    assign cdb_valid    = slot_busy[0];
    assign cdb_sel      = head_tag;
    assign unused_slots = ^slot_busy;

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Bench for cdb_issue_scheduler: directed and random ready patterns checked
// against a cycle-calendar model of CDB ownership and divider occupancy.
module tb_cdb_issue_scheduler;

    localparam int L_INT  = 1;
    localparam int L_MULT = 4;
    localparam int L_DIV  = 7;
    localparam int L_MEM  = 1;
    localparam int CAL_N  = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       int_ready = 1'b0, mult_ready = 1'b0, div_ready = 1'b0, mem_ready = 1'b0;
    logic       int_issue, mult_issue, div_issue, mem_issue;
    logic       div_busy, cdb_valid;
    logic [1:0] cdb_sel;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: cal[c] = owner of the CDB at absolute cycle c (-1 = free).
    int cal[CAL_N];
    int t;
    int div_last;
    bit rr_mem;

    always #5 clk = ~clk;

    cdb_issue_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .int_ready  (int_ready),
        .mult_ready (mult_ready),
        .div_ready  (div_ready),
        .mem_ready  (mem_ready),
        .int_issue  (int_issue),
        .mult_issue (mult_issue),
        .div_issue  (div_issue),
        .mem_issue  (mem_issue),
        .div_busy   (div_busy),
        .cdb_valid  (cdb_valid),
        .cdb_sel    (cdb_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CAL_N; i++) cal[i] = -1;
        t        = 0;
        div_last = -100;
        rr_mem   = 1'b0;
    endtask

    function automatic bit slot_free(input int c);
        return cal[c] < 0;
    endfunction

    // One scheduler cycle: drive readies, predict, compare, advance.
    task automatic step(input logic ir, input logic mr, input logic dr, input logic er);
        logic e_i, e_m, e_d, e_e, e_valid, e_busy;
        int   e_sel;
        @(negedge clk);
        int_ready  = ir;
        mult_ready = mr;
        div_ready  = dr;
        mem_ready  = er;
        #1;
        e_busy  = (t > div_last) && (t <= div_last + L_DIV);
        e_valid = !slot_free(t);
        e_sel   = e_valid ? cal[t] : 0;

        e_d = dr && (t >= div_last + L_DIV) && slot_free(t + L_DIV);
        if (e_d) begin
            cal[t + L_DIV] = 2;
            div_last = t;
        end
        e_m = mr && slot_free(t + L_MULT);
        if (e_m) cal[t + L_MULT] = 1;
        if (!rr_mem) begin
            e_i = ir && slot_free(t + L_INT);
            if (e_i) cal[t + L_INT] = 0;
            e_e = er && slot_free(t + L_MEM);
            if (e_e) cal[t + L_MEM] = 3;
        end else begin
            e_e = er && slot_free(t + L_MEM);
            if (e_e) cal[t + L_MEM] = 3;
            e_i = ir && slot_free(t + L_INT);
            if (e_i) cal[t + L_INT] = 0;
        end
        if (rr_mem ? e_e : e_i) rr_mem = !rr_mem;

        check("int_issue",  int_issue,  e_i);
        check("mult_issue", mult_issue, e_m);
        check("div_issue",  div_issue,  e_d);
        check("mem_issue",  mem_issue,  e_e);
        check("div_busy",   div_busy,   e_busy);
        check("cdb_valid",  cdb_valid,  e_valid);
        check("cdb_sel",    cdb_sel,    e_sel);
        t++;
    endtask

    // Asynchronous reset between edges, checked before the next clock edge.
    task automatic do_reset();
        @(negedge clk);
        int_ready  = 1'b1;
        mult_ready = 1'b1;
        div_ready  = 1'b1;
        mem_ready  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_int_issue",  int_issue,  1'b0);
        check("rst_mult_issue", mult_issue, 1'b0);
        check("rst_div_issue",  div_issue,  1'b0);
        check("rst_mem_issue",  mem_issue,  1'b0);
        check("rst_div_busy",   div_busy,   1'b0);
        check("rst_cdb_valid",  cdb_valid,  1'b0);
        check("rst_cdb_sel",    cdb_sel,    2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        int_ready  = 1'b0;
        mult_ready = 1'b0;
        div_ready  = 1'b0;
        mem_ready  = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Single INT op.
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // INT and MEM held: alternate starting at INT.
        do_reset();
        repeat (8) step(1, 0, 0, 1);
        step(0, 0, 0, 0);

        // MULT blocks a later INT on the same CDB cycle.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // DIV held: issues DIV_LAT apart.
        do_reset();
        repeat (16) step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);

        // All four held.
        do_reset();
        repeat (12) step(1, 1, 1, 1);
        repeat (8) step(0, 0, 0, 0);

        // Reset mid-flight drops the MULT reservation.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        do_reset();
        repeat (4) step(1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);

        // Random segments with varied ready density.
        for (int seg = 0; seg < 6; seg++) begin
            int pct;
            pct = $urandom_range(20, 90);
            do_reset();
            for (int n = 0; n < 300; n++) begin
                step($urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct,
                     $urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
